// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture_pkg                                                            |
// | Shared types for the PWM period/duty capture block.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pwm_capture_pkg;

  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW_DEF-1:0] period;
    logic [CW_DEF-1:0] duty;
    logic              timeout;
  } result_t;

endpackage
`default_nettype wire

// File: rtl/pwm_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_edge_detect                                                            |
// | Samples the PWM input and flags rising edges. Defining                     |
// | PWM_CAPTURE_SYNC_EN inserts a 2-flop synchronizer ahead of the sample reg. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise
);

  logic w_din;
  logic r_level;
  logic r_prev;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] r_sync;

  // Synchronizer resets high so a high input at reset release is not a rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_pwm};
    end
  end

  assign w_din = r_sync[1];
`else
  assign w_din = i_pwm;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_level <= w_din;
      r_prev  <= r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_capture                                                                |
// | Measures period and high time of a PWM waveform between rising edges and   |
// | presents each result on a valid/ready port. Optional input synchronizer is |
// | enabled with PWM_CAPTURE_SYNC_EN.                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          pwm_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] period,
  output logic [CW-1:0] duty,
  output logic          timeout,
  output logic          overrun
);

  localparam logic [CW-1:0] c_max    = {CW{1'b1}};
  localparam logic [CW-1:0] c_sat_at = c_max - {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_one    = {{(CW-1){1'b0}}, 1'b1};

  logic          w_level;
  logic          w_rise;
  logic [CW-1:0] w_level_ext;
  logic          w_rise_emit;
  logic          w_sat_emit;
  logic          w_emit;
  logic          w_load;
  logic [CW-1:0] w_new_period;
  logic [CW-1:0] w_new_duty;

  state_t        r_state;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] r_hcnt;
  logic          r_valid;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_duty;
  logic          r_timeout;
  logic          r_overrun;

  pwm_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_level_ext = {{(CW-1){1'b0}}, w_level};

  // Saturation fires on the cycle that would bring the span to 2**CW-1 cycles,
  // so the current sample is folded into the reported duty.
  always_comb begin
    w_rise_emit  = enable && (r_state == MEASURE) && w_rise;
    w_sat_emit   = enable && (r_state == MEASURE) && !w_rise && (r_pcnt == c_sat_at);
    w_emit       = w_rise_emit || w_sat_emit;
    w_load       = w_emit && (!r_valid || out_ready);
    w_new_period = w_rise ? r_pcnt : c_max;
    w_new_duty   = w_rise ? r_hcnt : (r_hcnt + w_level_ext);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pcnt    <= '0;
      r_hcnt    <= '0;
      r_valid   <= 1'b0;
      r_period  <= '0;
      r_duty    <= '0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid   <= 1'b1;
        r_period  <= w_new_period;
        r_duty    <= w_new_duty;
        r_timeout <= !w_rise;
      end else if (w_emit) begin
        r_overrun <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (!enable) begin
        r_state <= IDLE;
        r_pcnt  <= '0;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARMED;
          end
          ARMED: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_pcnt  <= c_one;
              r_hcnt  <= w_level_ext;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_pcnt <= c_one;
              r_hcnt <= w_level_ext;
            end else if (w_sat_emit) begin
              r_pcnt <= '0;
              r_hcnt <= '0;
            end else begin
              r_pcnt <= r_pcnt + c_one;
              r_hcnt <= r_hcnt + w_level_ext;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign period    = r_period;
  assign duty      = r_duty;
  assign timeout   = r_timeout;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pwm_capture                                                             |
// | Scoreboard bench: reference model predicts results, monitor checks them.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  localparam int CW   = CW_DEF;
  localparam int MAXP = (1 << CW) - 1;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int DLY     = 3;
  localparam int LAT_EXP = 3;
`else
  localparam int DLY     = 1;
  localparam int LAT_EXP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          pwm_in = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] period;
  logic [CW-1:0] duty;
  logic          timeout;
  logic          overrun;

  always #5 clk = ~clk;

  pwm_capture #(.CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .period    (period),
    .duty      (duty),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  int      n_checks = 0;
  int      n_fail   = 0;
  result_t exp_q[$];

  // Reference model state: level history, measurement mode, span counts, port state.
  logic    m_dl [3];
  logic    m_prev;
  int      m_mode;   // 0 idle, 1 waiting for first rise, 2 measuring
  int      m_span;
  int      m_high;
  bit      m_valid;
  bit      m_ovr;

  bit      lat_arm = 1'b0;
  int      lat_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_dl[i] = 1'b1;
    m_prev  = 1'b1;
    m_mode  = 0;
    m_span  = 0;
    m_high  = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  // One clock of the measurement rules, working on the level the block sees.
  task automatic model_fsm(input logic pin, input logic en, output bit has, output result_t r);
    logic lvl;
    logic rise;
    lvl = m_dl[DLY-1];
    for (int i = DLY - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
    m_dl[0] = pin;
    rise   = lvl & ~m_prev;
    m_prev = lvl;
    has = 1'b0;
    r   = '0;
    if (!en) begin
      m_mode = 0;
      m_span = 0;
      m_high = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode = 2;
        m_span = 1;
        m_high = int'(lvl);
      end
    end else if (rise) begin
      has       = 1'b1;
      r.period  = CW'(m_span);
      r.duty    = CW'(m_high);
      r.timeout = 1'b0;
      m_span    = 1;
      m_high    = int'(lvl);
    end else begin
      m_span = m_span + 1;
      m_high = m_high + int'(lvl);
      if (m_span == MAXP) begin
        has       = 1'b1;
        r.period  = CW'(m_span);
        r.duty    = CW'(m_high);
        r.timeout = 1'b1;
        m_span    = 0;
        m_high    = 0;
      end
    end
  endtask

  task automatic model_hs(input bit has, input result_t r, input logic rdy);
    if (has) begin
      if (!m_valid || rdy) begin
        exp_q.push_back(r);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready only when a result is produced, 3 random
  task automatic drive(input logic pin, input logic en, input int rmode);
    bit      has;
    result_t r;
    logic    rdy;
    model_fsm(pin, en, has, r);
    case (rmode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = has;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    pwm_in    = pin;
    enable    = en;
    out_ready = rdy;
    model_hs(has, r, rdy);
    @(posedge clk);
    #2;
  endtask

  task automatic pwm_periods(input int hi, input int lo, input int n, input int rmode);
    for (int k = 0; k < n; k++) begin
      repeat (hi) drive(1'b1, 1'b1, rmode);
      repeat (lo) drive(1'b0, 1'b1, rmode);
    end
  endtask

  task automatic pulse_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    chk("rst_valid", 64'(out_valid), 64'(m_valid));
    chk("rst_overrun", 64'(overrun), 64'(m_ovr));
    reset_n = 1'b1;
  endtask

  // Monitor: every accepted result is compared with the oldest prediction.
  always @(negedge clk) begin
    result_t e;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got period=%0d duty=%0d timeout=%0b expected none",
                 period, duty, timeout);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (period !== e.period || duty !== e.duty || timeout !== e.timeout) begin
          n_fail++;
          $display("FAIL result: got period=%0d duty=%0d timeout=%0b expected period=%0d duty=%0d timeout=%0b",
                   period, duty, timeout, e.period, e.duty, e.timeout);
        end
      end
    end
    if (lat_arm) begin
      lat_cnt++;
      if (out_valid) begin
        chk("latency", 64'(lat_cnt - 2), 64'(LAT_EXP));
        lat_arm = 1'b0;
      end else if (lat_cnt > 12) begin
        chk("latency_timeout", 64'(lat_cnt), 64'(LAT_EXP + 2));
        lat_arm = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_period", 64'(period), 64'(0));
    chk("reset_duty", 64'(duty), 64'(0));
    chk("reset_timeout", 64'(timeout), 64'(0));
    chk("reset_overrun", 64'(overrun), 64'(0));
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Constant waveform: 256-cycle period, 127 high.
    repeat (5) drive(1'b0, 1'b1, 1);
    pwm_periods(127, 129, 4, 1);

    // Ready asserted only on result cycles: replace-on-accept, no overrun.
    pwm_periods(2, 2, 8, 2);
    repeat (6) drive(1'b0, 1'b1, 1);
    chk("accept_on_emit_overrun", 64'(overrun), 64'(m_ovr));

    // Rise to out_valid latency.
    pwm_periods(3, 7, 3, 1);
    lat_arm = 1'b1;
    lat_cnt = 0;
    repeat (5) drive(1'b1, 1'b1, 1);
    repeat (5) drive(1'b0, 1'b1, 1);

    // Enable dropped mid-measurement, raised again while the input is low.
    pwm_periods(4, 6, 2, 1);
    repeat (2) drive(1'b1, 1'b1, 1);
    repeat (3) drive(1'b0, 1'b0, 1);
    repeat (3) drive(1'b0, 1'b1, 1);
    pwm_periods(4, 6, 3, 1);

    // Counter saturation on a constant high level after one rise.
    repeat (MAXP + 20) drive(1'b1, 1'b1, 1);
    repeat (10) drive(1'b0, 1'b1, 1);
    repeat (3) drive(1'b1, 1'b1, 1);
    repeat (5) drive(1'b0, 1'b1, 1);

    // Random waveforms, consumer always ready.
    for (int i = 0; i < 12; i++)
      pwm_periods(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 2, 1);

    // Stalled consumer: first result held, later ones dropped.
    repeat (6) drive(1'b0, 1'b1, 1);
    pwm_periods(2, 2, 5, 0);
    chk("stall_overrun", 64'(overrun), 64'(m_ovr));
    chk("stall_valid", 64'(out_valid), 64'(m_valid));
    pwm_periods(2, 2, 4, 1);

    // Random waveforms with random back-pressure.
    for (int i = 0; i < 12; i++)
      pwm_periods(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 2, 3);
    repeat (4) drive(1'b0, 1'b1, 1);
    chk("random_overrun", 64'(overrun), 64'(m_ovr));

    // Reset mid-period with input high at release.
    pwm_periods(127, 129, 1, 1);
    repeat (40) drive(1'b1, 1'b1, 1);
    pulse_reset(3);
    repeat (87) drive(1'b1, 1'b1, 1);
    repeat (129) drive(1'b0, 1'b1, 1);
    pwm_periods(127, 129, 2, 1);
    drive(1'b1, 1'b1, 1);

    repeat (10) drive(1'b0, 1'b1, 1);
    chk("final_overrun", 64'(overrun), 64'(m_ovr));
    chk("final_valid", 64'(out_valid), 64'(m_valid));
    chk("results_outstanding", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
